font_fetch_sched: RTL and testbench

- Schedules glyph-row reads from the shared synchronous font ROM (11-bit address = {char_code[6:0], row[3:0]}, 8-bit data) between two text requesters, e.g. the status-line generator and the clock/date overlay writer.
- Each request is a burst of consecutive glyph rows. The scheduler arbitrates round-robin, drives the ROM address one row per cycle, and returns every data word tagged with requester id, row and last flag.
- Sits between the text generators and the font ROM instance, and replaces direct ROM addressing by the generators.

---
 rtl/font_fetch_sched.sv | 130 +++++++++++++
 tb/tb_font_fetch_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/font_fetch_sched.sv
// Round-robin scheduler for glyph-row bursts into a shared synchronous font ROM.
// Rows issue one per cycle; a tag pipeline aligns id/row/last with the ROM output.
module font_fetch_sched #(
   parameter int unsigned ROM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [6:0]  char0,
   input  logic [3:0]  row0,
   input  logic [3:0]  nrows0_m1,
   output logic        ack0,
   input  logic        req1,
   input  logic [6:0]  char1,
   input  logic [3:0]  row1,
   input  logic [3:0]  nrows1_m1,
   output logic        ack1,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        out_valid,
   output logic        out_id,
   output logic [3:0]  out_row,
   output logic        out_last,
   output logic [7:0]  out_data,
   output logic        busy
);
   localparam int unsigned DEPTH = ROM_LAT + 1;

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e                state_q;
   logic                  rr_q;
   logic                  id_q;
   logic [6:0]            char_q;
   logic [3:0]            row_q;
   logic [3:0]            rem_q;
   logic [10:0]           addr_q;
   logic [DEPTH-1:0]      pv_q;
   logic [DEPTH-1:0]      pid_q;
   logic [DEPTH-1:0]      plast_q;
   logic [DEPTH-1:0][3:0] prow_q;

   logic       grant1;
   logic       accept;
   logic       iss_v_d;
   logic       iss_id_d;
   logic       iss_last_d;
   logic [6:0] iss_char_d;
   logic [3:0] iss_row_d;
   logic [3:0] nsel_d;

   always_comb begin
      grant1     = (req0 & req1) ? ~rr_q : req1;
      ack0       = 1'b0;
      ack1       = 1'b0;
      if (state_q == IDLE && reset) begin
         ack0 = req0 & ~grant1;
         ack1 = req1 & grant1;
      end
      accept     = ack0 | ack1;
      nsel_d     = grant1 ? nrows1_m1 : nrows0_m1;
      iss_v_d    = 1'b0;
      iss_id_d   = 1'b0;
      iss_last_d = 1'b0;
      iss_char_d = '0;
      iss_row_d  = '0;
      // rem_q counts rows still to issue after the one going out this edge
      if (state_q == ISSUE) begin
         iss_v_d    = 1'b1;
         iss_id_d   = id_q;
         iss_char_d = char_q;
         iss_row_d  = row_q;
         iss_last_d = (rem_q == 4'd0);
      end else if (accept) begin
         iss_v_d    = 1'b1;
         iss_id_d   = grant1;
         iss_char_d = grant1 ? char1 : char0;
         iss_row_d  = grant1 ? row1 : row0;
         iss_last_d = (nsel_d == 4'd0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rr_q    <= 1'b1;
         id_q    <= 1'b0;
         char_q  <= '0;
         row_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         pv_q    <= '0;
         pid_q   <= '0;
         plast_q <= '0;
         prow_q  <= '0;
      end else begin
         pv_q    <= {pv_q[DEPTH-2:0], iss_v_d};
         pid_q   <= {pid_q[DEPTH-2:0], iss_id_d};
         plast_q <= {plast_q[DEPTH-2:0], iss_last_d};
         prow_q  <= {prow_q[DEPTH-2:0], iss_row_d};
         if (iss_v_d) addr_q <= {iss_char_d, iss_row_d};
         case (state_q)
            IDLE: begin
               if (accept) begin
                  rr_q   <= grant1;
                  id_q   <= grant1;
                  char_q <= iss_char_d;
                  row_q  <= iss_row_d + 4'd1;
                  rem_q  <= nsel_d - 4'd1;
                  if (nsel_d != 4'd0) state_q <= ISSUE;
               end
            end
            ISSUE: begin
               row_q <= row_q + 4'd1;
               rem_q <= rem_q - 4'd1;
               if (rem_q == 4'd0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr  = addr_q;
   assign out_valid = pv_q[DEPTH-1];
   assign out_id    = pid_q[DEPTH-1];
   assign out_row   = prow_q[DEPTH-1];
   assign out_last  = plast_q[DEPTH-1];
   assign out_data  = rom_data;
   assign busy      = (state_q == ISSUE) | (|pv_q);
endmodule

// File: tb/tb_font_fetch_sched.sv
// Bench for font_fetch_sched: two instances (ROM_LAT=1 and 2) against a burst-schedule model.
module tb_font_fetch_sched;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic req0, req1;
   logic [6:0] char0, char1;
   logic [3:0] row0, row1, nrows0_m1, nrows1_m1;
   logic ack0_a, ack1_a, ov_a, oid_a, olast_a, busy_a;
   logic ack0_b, ack1_b, ov_b, oid_b, olast_b, busy_b;
   logic [3:0] orow_a, orow_b;
   logic [7:0] od_a, od_b, rd_a, rd_b1, rd_b2;
   logic [10:0] addr_a, addr_b;

   font_fetch_sched #(.ROM_LAT(1)) dut1 (
      .clk(clk), .reset(reset),
      .req0(req0), .char0(char0), .row0(row0), .nrows0_m1(nrows0_m1), .ack0(ack0_a),
      .req1(req1), .char1(char1), .row1(row1), .nrows1_m1(nrows1_m1), .ack1(ack1_a),
      .rom_addr(addr_a), .rom_data(rd_a),
      .out_valid(ov_a), .out_id(oid_a), .out_row(orow_a), .out_last(olast_a),
      .out_data(od_a), .busy(busy_a));

   font_fetch_sched #(.ROM_LAT(2)) dut2 (
      .clk(clk), .reset(reset),
      .req0(req0), .char0(char0), .row0(row0), .nrows0_m1(nrows0_m1), .ack0(ack0_b),
      .req1(req1), .char1(char1), .row1(row1), .nrows1_m1(nrows1_m1), .ack1(ack1_b),
      .rom_addr(addr_b), .rom_data(rd_b2),
      .out_valid(ov_b), .out_id(oid_b), .out_row(orow_b), .out_last(olast_b),
      .out_data(od_b), .busy(busy_b));

   function automatic logic [7:0] rom_f(input logic [10:0] a);
      return 8'((int'(a) * 37 + 11) % 256);
   endfunction

   always @(posedge clk) begin
      rd_a  <= rom_f(addr_a);
      rd_b1 <= rom_f(addr_b);
      rd_b2 <= rd_b1;
   end

   typedef struct {logic [6:0] ch; logic [3:0] row; logic [3:0] nm1;} rq_t;
   typedef struct {bit v; bit id; logic [3:0] row; bit last; logic [10:0] addr;} iss_t;

   rq_t  q0[$];
   rq_t  q1[$];
   iss_t iss[4096];
   int   checks = 0;
   int   failures = 0;
   int   ecnt = 0;
   int   next_acc = 0;
   int   last_iss = -1;
   bit   rr_m = 1'b1;
   logic [10:0] exp_addr = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic rq_t mk(input int ch, input int row, input int nm1);
      rq_t r;
      r.ch = 7'(ch); r.row = 4'(row); r.nm1 = 4'(nm1);
      return r;
   endfunction

   task automatic drive_inputs();
      req0 = (q0.size() > 0);
      req1 = (q1.size() > 0);
      if (req0) begin char0 = q0[0].ch; row0 = q0[0].row; nrows0_m1 = q0[0].nm1; end
      else begin char0 = 7'($urandom); row0 = 4'($urandom); nrows0_m1 = 4'($urandom); end
      if (req1) begin char1 = q1[0].ch; row1 = q1[0].row; nrows1_m1 = q1[0].nm1; end
      else begin char1 = 7'($urandom); row1 = 4'($urandom); nrows1_m1 = 4'($urandom); end
   endtask

   // Burst accepted at edge a: row k goes out at edge a+k; next accept possible at a+n.
   task automatic accept(input bit id, input rq_t r, input int a);
      int n;
      logic [3:0] rw;
      n = int'(r.nm1) + 1;
      for (int k = 0; k < n; k++) begin
         rw = r.row + 4'(k);
         iss[a+k].v = 1'b1; iss[a+k].id = id; iss[a+k].row = rw;
         iss[a+k].last = (k == n - 1); iss[a+k].addr = {r.ch, rw};
      end
      next_acc = a + n;
      last_iss = a + n - 1;
      rr_m = id;
   endtask

   task automatic check_dut(input int lat, input string p, input logic ov, input logic oid,
                            input logic [3:0] orow, input logic olast, input logic [7:0] od,
                            input logic bsy, input logic [10:0] addr);
      iss_t t;
      bit   eb;
      t = iss[ecnt-lat];
      eb = (ecnt < last_iss);
      for (int j = 0; j <= lat; j++) eb = eb | iss[ecnt-j].v;
      chk({p, ".rom_addr"}, 32'(addr), 32'(exp_addr));
      chk({p, ".busy"}, 32'(bsy), 32'(eb));
      chk({p, ".out_valid"}, 32'(ov), 32'(t.v));
      if (t.v) begin
         chk({p, ".out_id"}, 32'(oid), 32'(t.id));
         chk({p, ".out_row"}, 32'(orow), 32'(t.row));
         chk({p, ".out_last"}, 32'(olast), 32'(t.last));
         chk({p, ".out_data"}, 32'(od), 32'(rom_f(t.addr)));
      end
   endtask

   task automatic step();
      int a;
      bit g0, g1;
      drive_inputs();
      #1;
      a = ecnt + 1;
      g0 = 1'b0; g1 = 1'b0;
      if (a >= next_acc) begin
         if (req0 && req1) begin g0 = rr_m; g1 = !rr_m; end
         else begin g0 = req0; g1 = req1; end
      end
      chk("L1.ack0", 32'(ack0_a), 32'(g0));
      chk("L1.ack1", 32'(ack1_a), 32'(g1));
      chk("L2.ack0", 32'(ack0_b), 32'(g0));
      chk("L2.ack1", 32'(ack1_b), 32'(g1));
      if (g0) begin accept(1'b0, q0[0], a); void'(q0.pop_front()); end
      if (g1) begin accept(1'b1, q1[0], a); void'(q1.pop_front()); end
      @(posedge clk);
      ecnt++;
      if (ecnt >= 4000) begin
         $display("FAIL edge_budget observed=%0d expected=<4000", ecnt);
         $fatal(1, "edge budget exhausted");
      end
      @(negedge clk);
      if (iss[ecnt].v) exp_addr = iss[ecnt].addr;
      check_dut(1, "L1", ov_a, oid_a, orow_a, olast_a, od_a, busy_a, addr_a);
      check_dut(2, "L2", ov_b, oid_b, orow_b, olast_b, od_b, busy_b, addr_b);
   endtask

   task automatic reset_cycles(input int n);
      drive_inputs();
      reset = 1'b0;
      #1;
      chk("rst.L1.out_valid", 32'(ov_a), 32'd0);
      chk("rst.L1.busy", 32'(busy_a), 32'd0);
      chk("rst.L1.rom_addr", 32'(addr_a), 32'd0);
      chk("rst.L1.tag", {29'd0, oid_a, olast_a, |orow_a}, 32'd0);
      chk("rst.L1.ack", {30'd0, ack0_a, ack1_a}, 32'd0);
      chk("rst.L2.out_valid", 32'(ov_b), 32'd0);
      chk("rst.L2.busy", 32'(busy_b), 32'd0);
      chk("rst.L2.rom_addr", 32'(addr_b), 32'd0);
      chk("rst.L2.ack", {30'd0, ack0_b, ack1_b}, 32'd0);
      repeat (n) begin @(posedge clk); ecnt++; @(negedge clk); end
      for (int i = 0; i < 4096; i++) iss[i].v = 1'b0;
      next_acc = ecnt + 1;
      last_iss = -1;
      rr_m = 1'b1;
      exp_addr = '0;
      reset = 1'b1;
   endtask

   task automatic run_until_idle();
      for (int i = 0; i < 400; i++) begin
         if (q0.size() == 0 && q1.size() == 0 && ecnt > last_iss + 3) return;
         step();
      end
      checks++;
      failures++;
      $error("FAIL idle_timeout observed=busy expected=idle within 400 cycles");
   endtask

   initial begin
      q0.push_back(mk(8'h46, 0, 15));
      reset_cycles(3);
      run_until_idle();

      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk(8'h10 + i, i, 0));
         q1.push_back(mk(8'h20 + i, 15 - i, 0));
      end
      run_until_idle();

      q1.push_back(mk(8'h01, 14, 3));
      run_until_idle();

      q0.push_back(mk(8'h33, 5, 3));
      step();
      q1.push_back(mk(8'h55, 9, 1));
      run_until_idle();

      q0.push_back(mk(8'h7A, 2, 7));
      step();
      step();
      reset_cycles(2);
      q0.push_back(mk(8'h12, 3, 2));
      run_until_idle();

      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(1, 0) == 1)
            q0.push_back(mk(int'($urandom_range(127, 0)), int'($urandom_range(15, 0)),
                            ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0))
                                                        : int'($urandom_range(1, 0))));
         if ($urandom_range(1, 0) == 1)
            q1.push_back(mk(int'($urandom_range(127, 0)), int'($urandom_range(15, 0)),
                            ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0))
                                                        : int'($urandom_range(1, 0))));
         repeat ($urandom_range(3, 0)) step();
      end
      run_until_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
